banco_de_registradores_sb: RTL and testbench

Parametrised, clocked register file with N read ports, one write-back port, optional write-through bypass, optional hardwired-zero register 0, and an integrated busy-bit scoreboard. Sits between decode (reads operands, marks destinations busy) and write-back (commits results, clears busy). Gives decode operand data plus per-operand hazard status in the same cycle, and tracks how many registers have writes outstanding.

---
 rtl/banco_de_registradores_sb.sv | 128 ++++++++++++
 tb/tb_banco_de_registradores_sb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/banco_de_registradores_sb.sv
// banco_de_registradores_sb: register file with N combinational read ports,
// one write-back port, optional write-through bypass, optional hardwired
// zero register and an integrated busy-bit scoreboard with occupancy count.
module banco_de_registradores_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned N_RD     = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_RD*ADDR_W-1:0]   br_in_rd_addr,
  output logic [N_RD*DATA_W-1:0]   br_out_rd_data,
  output logic [N_RD-1:0]          br_out_rd_busy,
  input  logic                     sb_set_enable,
  input  logic [ADDR_W-1:0]        sb_set_addr,
  input  logic                     wb_enable,
  input  logic [ADDR_W-1:0]        br_in_dest_wb,
  input  logic [DATA_W-1:0]        br_in_data,
  output logic [ADDR_W:0]          br_out_busy_count,
  output logic                     br_out_wb_orphan
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam bit          ZERO_EN = (ZERO_REG != 0);
  localparam bit          BYP_EN  = (BYPASS != 0);

  // Architectural state
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [CNT_W-1:0]  r_count;
  logic              r_orphan;

  // Next-state and qualifier nets
  logic [DEPTH-1:0]  w_busy_next;
  logic [CNT_W-1:0]  w_count_next;
  logic              w_set_ok;
  logic              w_wb_ok;
  logic              w_inc;
  logic              w_dec;
  logic              w_orphan_hit;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_rd_hit;
  logic              w_rd_zero;

  // Qualify set / write-back against the hardwired zero register
  always_comb begin
    w_set_ok = sb_set_enable && !(ZERO_EN && (sb_set_addr == '0));
    w_wb_ok  = wb_enable && !(ZERO_EN && (br_in_dest_wb == '0));
  end

  // Read ports: array data, optional bypass, zero-register override, forwarded busy
  always_comb begin
    br_out_rd_data = '0;
    br_out_rd_busy = '0;
    w_rd_addr      = '0;
    w_rd_hit       = 1'b0;
    w_rd_zero      = 1'b0;
    for (int unsigned i = 0; i < N_RD; i++) begin
      w_rd_addr = br_in_rd_addr[i*ADDR_W +: ADDR_W];
      w_rd_hit  = wb_enable && (br_in_dest_wb == w_rd_addr);
      w_rd_zero = ZERO_EN && (w_rd_addr == '0);
      if (w_rd_zero) begin
        br_out_rd_data[i*DATA_W +: DATA_W] = '0;
        br_out_rd_busy[i]                  = 1'b0;
      end else begin
        br_out_rd_data[i*DATA_W +: DATA_W] = (BYP_EN && w_rd_hit) ? br_in_data
                                                                  : r_mem[w_rd_addr];
        br_out_rd_busy[i]                  = r_busy[w_rd_addr] && !w_rd_hit;
      end
    end
  end

  // Busy vector next state: a new producer (set) wins over a retiring one (clear)
  always_comb begin
    w_busy_next = r_busy;
    if (w_wb_ok) begin
      w_busy_next[br_in_dest_wb] = 1'b0;
    end
    if (w_set_ok) begin
      w_busy_next[sb_set_addr] = 1'b1;
    end
  end

  // Occupancy count tracks popcount(busy) incrementally
  always_comb begin
    w_inc        = w_set_ok && !r_busy[sb_set_addr];
    w_dec        = w_wb_ok && r_busy[br_in_dest_wb]
                   && !(w_set_ok && (sb_set_addr == br_in_dest_wb));
    w_count_next = r_count + CNT_W'(w_inc) - CNT_W'(w_dec);
    w_orphan_hit = w_wb_ok && !r_busy[br_in_dest_wb];
  end

  // Register array storage with write-back commit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        r_mem[j] <= '0;
      end
    end else if (w_wb_ok) begin
      r_mem[br_in_dest_wb] <= br_in_data;
    end
  end

  // Scoreboard state: busy bits, count and sticky orphan flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_busy   <= '0;
      r_count  <= '0;
      r_orphan <= 1'b0;
    end else begin
      r_busy  <= w_busy_next;
      r_count <= w_count_next;
      if (w_orphan_hit) begin
        r_orphan <= 1'b1;
      end
    end
  end

  // Status outputs straight from state flops
  always_comb begin
    br_out_busy_count = r_count;
    br_out_wb_orphan  = r_orphan;
  end

endmodule

// File: tb/tb_banco_de_registradores_sb.sv
// Directed testbench for banco_de_registradores_sb (default parameters plus a
// no-bypass instance sharing the same stimulus for the bypass comparison).
module tb_banco_de_registradores_sb;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned N_RD   = 2;

  logic                   clock;
  logic                   reset;
  logic [N_RD*ADDR_W-1:0] br_in_rd_addr;
  logic [N_RD*DATA_W-1:0] br_out_rd_data;
  logic [N_RD-1:0]        br_out_rd_busy;
  logic                   sb_set_enable;
  logic [ADDR_W-1:0]      sb_set_addr;
  logic                   wb_enable;
  logic [ADDR_W-1:0]      br_in_dest_wb;
  logic [DATA_W-1:0]      br_in_data;
  logic [ADDR_W:0]        br_out_busy_count;
  logic                   br_out_wb_orphan;

  logic [N_RD*DATA_W-1:0] nb_rd_data;
  logic [N_RD-1:0]        nb_rd_busy;
  logic [ADDR_W:0]        nb_busy_count;
  logic                   nb_wb_orphan;

  int n_chk;
  int n_fail;

  banco_de_registradores_sb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clock(clock), .reset(reset),
    .br_in_rd_addr(br_in_rd_addr), .br_out_rd_data(br_out_rd_data),
    .br_out_rd_busy(br_out_rd_busy),
    .sb_set_enable(sb_set_enable), .sb_set_addr(sb_set_addr),
    .wb_enable(wb_enable), .br_in_dest_wb(br_in_dest_wb), .br_in_data(br_in_data),
    .br_out_busy_count(br_out_busy_count), .br_out_wb_orphan(br_out_wb_orphan)
  );

  banco_de_registradores_sb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD), .ZERO_REG(0), .BYPASS(0)
  ) dut_nb (
    .clock(clock), .reset(reset),
    .br_in_rd_addr(br_in_rd_addr), .br_out_rd_data(nb_rd_data),
    .br_out_rd_busy(nb_rd_busy),
    .sb_set_enable(sb_set_enable), .sb_set_addr(sb_set_addr),
    .wb_enable(wb_enable), .br_in_dest_wb(br_in_dest_wb), .br_in_data(br_in_data),
    .br_out_busy_count(nb_busy_count), .br_out_wb_orphan(nb_wb_orphan)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: count and report mismatches
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    sb_set_enable = 1'b0;
    wb_enable     = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    br_in_rd_addr = {a1, a0};
  endtask

  task automatic set_b(input logic [ADDR_W-1:0] a);
    sb_set_enable = 1'b1;
    sb_set_addr   = a;
  endtask

  task automatic wb(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wb_enable     = 1'b1;
    br_in_dest_wb = a;
    br_in_data    = d;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b0;
    br_in_rd_addr = '0;
    sb_set_enable = 1'b0;
    sb_set_addr   = '0;
    wb_enable     = 1'b0;
    br_in_dest_wb = '0;
    br_in_data    = '0;
    rd(5'd5, 5'd7);
    #3;
    chk("rst_data0", br_out_rd_data[31:0], 32'h0);
    chk("rst_busy", br_out_rd_busy, 2'b00);
    chk("rst_count", br_out_busy_count, 6'd0);
    chk("rst_orphan", br_out_wb_orphan, 1'b0);
    step();
    reset = 1'b1;

    // Reset mid-operation
    step();
    wb(5'd5, 32'hDEADBEEF);
    set_b(5'd7);
    step();
    idle();
    #1;
    chk("pre_rst_r5", br_out_rd_data[31:0], 32'hDEADBEEF);
    chk("pre_rst_busy7", br_out_rd_busy[1], 1'b1);
    chk("pre_rst_count", br_out_busy_count, 6'd1);
    chk("pre_rst_orphan", br_out_wb_orphan, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_r5", br_out_rd_data[31:0], 32'h0);
    chk("mid_rst_busy7", br_out_rd_busy[1], 1'b0);
    chk("mid_rst_count", br_out_busy_count, 6'd0);
    chk("mid_rst_orphan", br_out_wb_orphan, 1'b0);
    reset = 1'b1;

    // Scoreboard set/set/clear sequence
    step();
    set_b(5'd3);
    rd(5'd3, 5'd4);
    #1;
    chk("sb_c0_count", br_out_busy_count, 6'd0);
    step();
    set_b(5'd4);
    #1;
    chk("sb_c1_count", br_out_busy_count, 6'd1);
    chk("sb_c1_busy3", br_out_rd_busy[0], 1'b1);
    step();
    sb_set_enable = 1'b0;
    wb(5'd3, 32'h11);
    #1;
    chk("sb_c2_count", br_out_busy_count, 6'd2);
    chk("sb_c2_busy3_fwd", br_out_rd_busy[0], 1'b0);
    chk("sb_c2_data3_byp", br_out_rd_data[31:0], 32'h11);
    chk("sb_c2_busy4", br_out_rd_busy[1], 1'b1);
    step();
    idle();
    #1;
    chk("sb_c3_count", br_out_busy_count, 6'd1);
    chk("sb_c3_busy3", br_out_rd_busy[0], 1'b0);
    chk("sb_c3_data3", br_out_rd_data[31:0], 32'h11);
    chk("sb_orphan", br_out_wb_orphan, 1'b0);

    // Bypass: preload R9 keeping it busy, then commit with both ports reading R9
    set_b(5'd9);
    rd(5'd9, 5'd9);
    step();
    wb(5'd9, 32'h1);
    #1;
    chk("byp_pre_count", br_out_busy_count, 6'd2);
    step();
    sb_set_enable = 1'b0;
    wb(5'd9, 32'h12345678);
    #1;
    chk("byp_hold_count", br_out_busy_count, 6'd2);
    chk("byp_port0", br_out_rd_data[31:0], 32'h12345678);
    chk("byp_port1", br_out_rd_data[63:32], 32'h12345678);
    chk("nobyp_port0_old", nb_rd_data[31:0], 32'h1);
    chk("nobyp_port1_old", nb_rd_data[63:32], 32'h1);
    step();
    idle();
    #1;
    chk("nobyp_port0_new", nb_rd_data[31:0], 32'h12345678);
    chk("byp_after_r9", br_out_rd_data[31:0], 32'h12345678);
    chk("byp_after_count", br_out_busy_count, 6'd1);
    chk("byp_orphan", br_out_wb_orphan, 1'b0);

    // Same-address set+clear on a busy register
    set_b(5'd6);
    rd(5'd6, 5'd4);
    step();
    wb(5'd6, 32'hA5);
    #1;
    chk("sa_pre_count", br_out_busy_count, 6'd2);
    chk("sa_fwd_busy", br_out_rd_busy[0], 1'b0);
    chk("sa_fwd_data", br_out_rd_data[31:0], 32'hA5);
    step();
    idle();
    #1;
    chk("sa_busy6", br_out_rd_busy[0], 1'b1);
    chk("sa_count", br_out_busy_count, 6'd2);
    chk("sa_data6", br_out_rd_data[31:0], 32'hA5);
    chk("sa_orphan", br_out_wb_orphan, 1'b0);

    // Zero register ignores writes and busy-set
    wb(5'd0, 32'hFFFFFFFF);
    set_b(5'd0);
    rd(5'd0, 5'd8);
    #1;
    chk("z_fwd_data", br_out_rd_data[31:0], 32'h0);
    chk("z_fwd_busy", br_out_rd_busy[0], 1'b0);
    step();
    idle();
    #1;
    chk("z_data", br_out_rd_data[31:0], 32'h0);
    chk("z_busy", br_out_rd_busy[0], 1'b0);
    chk("z_count", br_out_busy_count, 6'd2);
    chk("z_orphan", br_out_wb_orphan, 1'b0);

    // Orphan write-back to non-busy R8, then sticky under further traffic
    wb(5'd8, 32'h77);
    #1;
    chk("orph_pre", br_out_wb_orphan, 1'b0);
    step();
    idle();
    #1;
    chk("orph_set", br_out_wb_orphan, 1'b1);
    chk("orph_r8", br_out_rd_data[63:32], 32'h77);
    chk("orph_count", br_out_busy_count, 6'd2);
    wb(5'd4, 32'h44);
    step();
    idle();
    #1;
    chk("orph_sticky", br_out_wb_orphan, 1'b1);
    chk("orph_end_count", br_out_busy_count, 6'd1);
    step();
    chk("orph_sticky2", br_out_wb_orphan, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
